// File: rtl/dmem_arbiter_if.sv
`timescale 1ns / 1ps
// Requester, response and memory-side signals of the data memory arbiter.
// slave: the arbiter itself; master: the requesters plus the data memory.
interface dmem_arbiter_if;
    logic [1:0]  iReqValid;
    logic [1:0]  iReqWrite;
    logic [31:0] iReqAddr0;
    logic [31:0] iReqAddr1;
    logic [31:0] iReqWData0;
    logic [31:0] iReqWData1;
    logic [2:0]  iReqFunct3_0;
    logic [2:0]  iReqFunct3_1;
    logic [1:0]  oReqReady;
    logic [1:0]  oRspValid;
    logic [1:0]  iRspReady;
    logic [31:0] oRspData;
    logic        oRspErr;
    logic [31:0] oMemAddress;
    logic [31:0] oMemWriteData;
    logic [2:0]  oMemFunct3;
    logic        oMemWrite;
    logic        oMemRead;
    logic [31:0] iMemReadData;

    modport slave (
        input  iReqValid, iReqWrite, iReqAddr0, iReqAddr1, iReqWData0, iReqWData1,
        input  iReqFunct3_0, iReqFunct3_1, iRspReady, iMemReadData,
        output oReqReady, oRspValid, oRspData, oRspErr,
        output oMemAddress, oMemWriteData, oMemFunct3, oMemWrite, oMemRead
    );

    modport master (
        output iReqValid, iReqWrite, iReqAddr0, iReqAddr1, iReqWData0, iReqWData1,
        output iReqFunct3_0, iReqFunct3_1, iRspReady, iMemReadData,
        input  oReqReady, oRspValid, oRspData, oRspErr,
        input  oMemAddress, oMemWriteData, oMemFunct3, oMemWrite, oMemRead
    );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns / 1ps
// Two-port data memory arbiter: grants one requester, validates the access,
// drives the memory for a single cycle and holds the response until consumed.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES  = 4096,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input logic           iClk,
    input logic           iRstN,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} stateE;

    stateE       stateQ, stateD;

    logic [1:0]  grant;
    logic        selPort;
    logic [31:0] selAddr;
    logic [31:0] selWData;
    logic [2:0]  selFunct3;
    logic        selWrite;
    logic [2:0]  accSize;
    logic        badFunct3;
    logic        misaligned;
    logic        outOfRange;
    logic        selErr;

    logic [31:0] addrQ;
    logic [31:0] wDataQ;
    logic [2:0]  funct3Q;
    logic        writeQ;
    logic        portQ;
    logic        errQ;
    logic [31:0] rDataQ;
    // 1 = port 1 was granted last, so port 0 wins the next tie
    logic        lastGrantQ;

    // Pick the winner while idle; reset forces no grant so outputs stay 0
    always_comb begin
        grant = 2'b00;
        if (iRstN && stateQ == StIdle) begin
            case (bus.iReqValid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (FIXED_PRIO || lastGrantQ) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Steer the winning port's request fields
    always_comb begin
        selPort   = grant[1];
        selAddr   = selPort ? bus.iReqAddr1    : bus.iReqAddr0;
        selWData  = selPort ? bus.iReqWData1   : bus.iReqWData0;
        selFunct3 = selPort ? bus.iReqFunct3_1 : bus.iReqFunct3_0;
        selWrite  = selPort ? bus.iReqWrite[1] : bus.iReqWrite[0];
    end

    // Validate funct3, alignment and range before anything reaches memory
    always_comb begin
        case (selFunct3[1:0])
            2'b00:   accSize = 3'd1;
            2'b01:   accSize = 3'd2;
            default: accSize = 3'd4;
        endcase
        if (selWrite) begin
            badFunct3 = selFunct3[2] || (selFunct3[1:0] == 2'b11);
        end else begin
            badFunct3 = (selFunct3[1:0] == 2'b11) || (selFunct3[2] && selFunct3[1]);
        end
        misaligned = ((selFunct3[1:0] == 2'b01) && selAddr[0]) ||
                     ((selFunct3[1:0] == 2'b10) && (selAddr[1:0] != 2'b00));
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        outOfRange = ({1'b0, selAddr} + {30'b0, accSize}) > 33'(MEM_BYTES);
        selErr     = badFunct3 || misaligned || outOfRange;
    end

    // FSM state register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state and handshake / memory strobes
    always_comb begin
        stateD        = stateQ;
        bus.oReqReady = grant;
        bus.oRspValid = 2'b00;
        bus.oRspData  = 32'h0;
        bus.oRspErr   = 1'b0;
        bus.oMemWrite = 1'b0;
        bus.oMemRead  = 1'b0;
        case (stateQ)
            StIdle: begin
                if (grant != 2'b00) begin
                    stateD = StAccess;
                end
            end
            StAccess: begin
                bus.oMemWrite = !errQ && writeQ;
                bus.oMemRead  = !errQ && !writeQ;
                stateD        = StResp;
            end
            StResp: begin
                bus.oRspValid = portQ ? 2'b10 : 2'b01;
                bus.oRspData  = rDataQ;
                bus.oRspErr   = errQ;
                if (bus.iRspReady[portQ]) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Request latches, response data capture and last-grant pointer
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            addrQ      <= 32'h0;
            wDataQ     <= 32'h0;
            funct3Q    <= 3'b000;
            writeQ     <= 1'b0;
            portQ      <= 1'b0;
            errQ       <= 1'b0;
            rDataQ     <= 32'h0;
            lastGrantQ <= 1'b1;
        end else begin
            if (grant != 2'b00) begin
                addrQ      <= selAddr;
                wDataQ     <= selWData;
                funct3Q    <= selFunct3;
                writeQ     <= selWrite;
                portQ      <= selPort;
                errQ       <= selErr;
                lastGrantQ <= selPort;
            end
            if (stateQ == StAccess) begin
                // Stores and rejected accesses respond with zero data
                rDataQ <= (errQ || writeQ) ? 32'h0 : bus.iMemReadData;
            end
        end
    end

    // Memory address/data/funct3 simply hold the last latched request
    assign bus.oMemAddress   = addrQ;
    assign bus.oMemWriteData = wDataQ;
    assign bus.oMemFunct3    = funct3Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns / 1ps
// Bench for dmem_arbiter: behavioural data memory, directed scenarios and a
// randomized two-port stream checked against a transaction-level model.
module tb_dmem_arbiter;

    logic iClk = 1'b0;
    logic iRstN = 1'b0;
    always #5 iClk = ~iClk;

    dmem_arbiter_if bus ();
    dmem_arbiter_if busF ();

    dmem_arbiter #(.MEM_BYTES(4096), .FIXED_PRIO(1'b0)) dut (
        .iClk(iClk), .iRstN(iRstN), .bus(bus.slave)
    );
    dmem_arbiter #(.MEM_BYTES(4096), .FIXED_PRIO(1'b1)) dutF (
        .iClk(iClk), .iRstN(iRstN), .bus(busF.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem    [4096];
    logic [7:0]  refMem [4096];
    logic        memInit;
    logic [11:0] ra0, ra1, ra2, ra3;

    assign ra0 = bus.oMemAddress[11:0];
    assign ra1 = ra0 + 12'd1;
    assign ra2 = ra0 + 12'd2;
    assign ra3 = ra0 + 12'd3;

    // Memory of the fixed-priority instance: loads return a tag of the address
    assign busF.iMemReadData = busF.oMemAddress ^ 32'hA5A5_0000;

    // Behavioural data memory: combinational read with sign/zero extension
    always_comb begin
        bus.iMemReadData = 32'h0;
        case (bus.oMemFunct3)
            3'b000:  bus.iMemReadData = {{24{mem[ra0][7]}}, mem[ra0]};
            3'b100:  bus.iMemReadData = {24'h0, mem[ra0]};
            3'b001:  bus.iMemReadData = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
            3'b101:  bus.iMemReadData = {16'h0, mem[ra1], mem[ra0]};
            default: bus.iMemReadData = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
        endcase
    end

    // Behavioural data memory: store commit on the rising edge
    always @(posedge iClk) begin
        if (memInit) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'((i * 37 + 5) & 255);
        end else if (bus.oMemWrite) begin
            mem[ra0] <= bus.oMemWriteData[7:0];
            if (bus.oMemFunct3[1:0] != 2'b00) mem[ra1] <= bus.oMemWriteData[15:8];
            if (bus.oMemFunct3[1:0] == 2'b10) begin
                mem[ra2] <= bus.oMemWriteData[23:16];
                mem[ra3] <= bus.oMemWriteData[31:24];
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit ref_err(input bit wr, input logic [31:0] addr, input logic [2:0] f3);
        bit bad;
        int sz;
        sz  = acc_size(f3);
        bad = wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (sz == 2 && addr[0]) bad = 1'b1;
        if (sz == 4 && addr[1:0] != 2'b00) bad = 1'b1;
        if ({32'h0, addr} + 64'(sz) > 64'd4096) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = refMem[12'(addr[11:0] + 12'(i))];
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        for (int i = 0; i < acc_size(f3); i++) refMem[12'(addr[11:0] + 12'(i))] = wd[8*i +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input int p, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3);
        if (p == 0) begin
            bus.iReqAddr0 = addr; bus.iReqWData0 = wd; bus.iReqFunct3_0 = f3;
        end else begin
            bus.iReqAddr1 = addr; bus.iReqWData1 = wd; bus.iReqFunct3_1 = f3;
        end
        bus.iReqWrite[p] = wr;
        bus.iReqValid[p] = 1'b1;
    endtask

    // One complete transaction from IDLE with cycle-exact checks; starts and ends just after a rise
    task automatic run_txn(input string name, input int p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] expData, input bit expErr);
        logic [1:0] oh, strobe;
        oh     = (p == 0) ? 2'b01 : 2'b10;
        strobe = expErr ? 2'b00 : (wr ? 2'b10 : 2'b01);
        bus.iRspReady = 2'b11;
        drive_req(p, wr, addr, wd, f3);
        @(negedge iClk);
        checks++;
        if (bus.oReqReady !== oh || {bus.oMemWrite, bus.oMemRead} !== 2'b00) begin
            errors++;
            $display("FAIL %s accept: ready=%b wr/rd=%b, want ready=%b wr/rd=00", name,
                     bus.oReqReady, {bus.oMemWrite, bus.oMemRead}, oh);
        end
        @(posedge iClk); #1;
        bus.iReqValid[p] = 1'b0;
        @(negedge iClk);
        checks++;
        if ({bus.oMemWrite, bus.oMemRead} !== strobe || bus.oReqReady !== 2'b00 ||
            bus.oRspValid !== 2'b00) begin
            errors++;
            $display("FAIL %s access: wr/rd=%b ready=%b rspv=%b, want wr/rd=%b ready=00 rspv=00",
                     name, {bus.oMemWrite, bus.oMemRead}, bus.oReqReady, bus.oRspValid, strobe);
        end
        if (!expErr) begin
            checks++;
            if (bus.oMemAddress !== addr || bus.oMemFunct3 !== f3 ||
                (wr && bus.oMemWriteData !== wd)) begin
                errors++;
                $display("FAIL %s membus: addr=%h f3=%b wd=%h, want addr=%h f3=%b wd=%h", name,
                         bus.oMemAddress, bus.oMemFunct3, bus.oMemWriteData, addr, f3, wd);
            end
        end
        @(posedge iClk); #1;
        @(negedge iClk);
        checks++;
        if (bus.oRspValid !== oh || bus.oRspData !== expData || bus.oRspErr !== expErr ||
            {bus.oMemWrite, bus.oMemRead} !== 2'b00) begin
            errors++;
            $display("FAIL %s rsp: rspv=%b data=%h err=%b wr/rd=%b, want rspv=%b data=%h err=%b",
                     name, bus.oRspValid, bus.oRspData, bus.oRspErr,
                     {bus.oMemWrite, bus.oMemRead}, oh, expData, expErr);
        end
        @(posedge iClk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.iReqValid  = 2'b11;
        busF.iReqValid = 2'b11;
        @(negedge iClk);
        checks++;
        if ({bus.oReqReady, bus.oRspValid, bus.oRspData, bus.oRspErr, bus.oMemAddress,
             bus.oMemWriteData, bus.oMemFunct3, bus.oMemWrite, bus.oMemRead} !== '0 ||
            {busF.oReqReady, busF.oRspValid, busF.oMemWrite, busF.oMemRead} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rspv=%b addr=%h wr/rd=%b, want all 0",
                     bus.oReqReady, bus.oRspValid, bus.oMemAddress, {bus.oMemWrite, bus.oMemRead});
        end
        bus.iReqValid  = 2'b00;
        busF.iReqValid = 2'b00;
        @(posedge iClk); #1;
        memInit = 1'b0;
        iRstN   = 1'b1;
        @(negedge iClk);
        checks++;
        if (bus.oReqReady !== 2'b00 || bus.oRspValid !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: ready=%b rspv=%b, want 00 00", bus.oReqReady, bus.oRspValid);
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_store_load();
        run_txn("sw_0x10", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        ref_store(32'h10, 32'hDEAD_BEEF, 3'b010);
        checks++;
        if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_commit: mem=%h, want deadbeef", {mem[19], mem[18], mem[17], mem[16]});
        end
        run_txn("lw_0x10", 0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);
        run_txn("lb_0x13", 1, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0);
        run_txn("lhu_0x12", 0, 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_DEAD, 1'b0);
    endtask

    task automatic test_errors();
        logic [7:0] b14;
        b14 = refMem[12'h014];
        run_txn("lh_0x13", 1, 1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1);
        run_txn("sh_0x13", 1, 1'b1, 32'h13, 32'h1234_5678, 3'b001, 32'h0, 1'b1);
        checks++;
        if (mem[12'h013] !== 8'hDE || mem[12'h014] !== b14) begin
            errors++;
            $display("FAIL sh_0x13_intact: mem13=%h mem14=%h, want de %h", mem[12'h013],
                     mem[12'h014], b14);
        end
        run_txn("lw_0xffc", 0, 1'b0, 32'hFFC, 32'h0, 3'b010, ref_load(32'hFFC, 3'b010), 1'b0);
        run_txn("lw_0xffe", 0, 1'b0, 32'hFFE, 32'h0, 3'b010, 32'h0, 1'b1);
        run_txn("lb_0x1000", 0, 1'b0, 32'h1000, 32'h0, 3'b000, 32'h0, 1'b1);
        run_txn("lbu_0xfff", 0, 1'b0, 32'hFFF, 32'h0, 3'b100, ref_load(32'hFFF, 3'b100), 1'b0);
        run_txn("lhu_0xffe", 1, 1'b0, 32'hFFE, 32'h0, 3'b101, ref_load(32'hFFE, 3'b101), 1'b0);
        run_txn("ld_f3_011", 0, 1'b0, 32'h40, 32'h0, 3'b011, 32'h0, 1'b1);
        run_txn("ld_f3_110", 1, 1'b0, 32'h40, 32'h0, 3'b110, 32'h0, 1'b1);
        run_txn("st_f3_100", 0, 1'b1, 32'h40, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1);
        run_txn("sw_wrap", 1, 1'b1, 32'hFFFF_FFFC, 32'h1, 3'b010, 32'h0, 1'b1);
        checks++;
        if ({mem[67], mem[66], mem[65], mem[64]} !== ref_load(32'h40, 3'b010)) begin
            errors++;
            $display("FAIL st_f3_100_intact: mem=%h, want %h", {mem[67], mem[66], mem[65], mem[64]},
                     ref_load(32'h40, 3'b010));
        end
    endtask

    task automatic test_backpressure();
        bus.iRspReady = 2'b00;
        drive_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        @(negedge iClk);
        checks++;
        if (bus.oReqReady !== 2'b01) begin
            errors++;
            $display("FAIL bp_accept: ready=%b, want 01", bus.oReqReady);
        end
        @(posedge iClk); #1;
        bus.iReqValid[0] = 1'b0;
        drive_req(1, 1'b0, 32'h40, 32'h0, 3'b010);
        bus.iRspReady = 2'b10;  // ready on the wrong port must be ignored
        @(negedge iClk);
        for (int i = 0; i < 5; i++) begin
            @(posedge iClk); #1;
            @(negedge iClk);
            checks++;
            if (bus.oRspValid !== 2'b01 || bus.oRspData !== 32'hDEAD_BEEF ||
                bus.oRspErr !== 1'b0 || bus.oReqReady !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: rspv=%b data=%h err=%b ready=%b, want 01 deadbeef 0 00",
                         i, bus.oRspValid, bus.oRspData, bus.oRspErr, bus.oReqReady);
            end
        end
        @(posedge iClk); #1;
        bus.iRspReady = 2'b01;
        @(negedge iClk);
        @(posedge iClk); #1;
        bus.iRspReady = 2'b11;
        @(negedge iClk);
        checks++;
        if (bus.oRspValid !== 2'b00 || bus.oReqReady !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: rspv=%b ready=%b, want 00 10", bus.oRspValid, bus.oReqReady);
        end
        @(posedge iClk); #1;
        bus.iReqValid[1] = 1'b0;
        @(negedge iClk);
        @(posedge iClk); #1;
        @(negedge iClk);
        checks++;
        if (bus.oRspValid !== 2'b10 || bus.oRspData !== ref_load(32'h40, 3'b010)) begin
            errors++;
            $display("FAIL bp_port1_rsp: rspv=%b data=%h, want 10 %h", bus.oRspValid,
                     bus.oRspData, ref_load(32'h40, 3'b010));
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0]  expG;
        logic [31:0] expD;
        int          n;
        bus.iRspReady = 2'b11;
        drive_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        drive_req(1, 1'b0, 32'h40, 32'h0, 3'b010);
        for (int g = 0; g < 4; g++) begin
            expG = (g % 2 == 0) ? 2'b01 : 2'b10;
            expD = expG[0] ? 32'hDEAD_BEEF : ref_load(32'h40, 3'b010);
            n = 0;
            @(negedge iClk);
            while (bus.oReqReady == 2'b00 && n < 8) begin @(negedge iClk); n++; end
            checks++;
            if (bus.oReqReady !== expG) begin
                errors++;
                $display("FAIL rr_grant%0d: ready=%b, want %b", g, bus.oReqReady, expG);
            end
            if (g == 3) begin
                @(posedge iClk); #1;
                bus.iReqValid = 2'b00;
            end
            n = 0;
            @(negedge iClk);
            while (bus.oRspValid == 2'b00 && n < 8) begin @(negedge iClk); n++; end
            checks++;
            if (bus.oRspValid !== expG || bus.oRspData !== expD) begin
                errors++;
                $display("FAIL rr_rsp%0d: rspv=%b data=%h, want %b %h", g, bus.oRspValid,
                         bus.oRspData, expG, expD);
            end
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_fixed_prio();
        logic [1:0]  expG;
        logic [31:0] expD;
        int          n;
        busF.iRspReady    = 2'b11;
        busF.iReqWrite    = 2'b00;
        busF.iReqAddr0    = 32'h100;
        busF.iReqAddr1    = 32'h200;
        busF.iReqFunct3_0 = 3'b010;
        busF.iReqFunct3_1 = 3'b010;
        busF.iReqValid    = 2'b11;
        for (int g = 0; g < 5; g++) begin
            expG = (g < 4) ? 2'b01 : 2'b10;
            expD = (g < 4) ? 32'hA5A5_0100 : 32'hA5A5_0200;
            n = 0;
            @(negedge iClk);
            while (busF.oReqReady == 2'b00 && n < 8) begin @(negedge iClk); n++; end
            checks++;
            if (busF.oReqReady !== expG) begin
                errors++;
                $display("FAIL fp_grant%0d: ready=%b, want %b", g, busF.oReqReady, expG);
            end
            if (g >= 3) begin
                @(posedge iClk); #1;
                busF.iReqValid[g - 3] = 1'b0;
            end
            n = 0;
            @(negedge iClk);
            while (busF.oRspValid == 2'b00 && n < 8) begin @(negedge iClk); n++; end
            checks++;
            if (busF.oRspValid !== expG || busF.oRspData !== expD) begin
                errors++;
                $display("FAIL fp_rsp%0d: rspv=%b data=%h, want %b %h", g, busF.oRspValid,
                         busF.oRspData, expG, expD);
            end
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_reset_mid();
        bus.iRspReady = 2'b11;
        drive_req(0, 1'b1, 32'h20, 32'h0000_0077, 3'b000);
        @(negedge iClk);
        checks++;
        if (bus.oReqReady !== 2'b01) begin
            errors++;
            $display("FAIL rst_sb_accept: ready=%b, want 01", bus.oReqReady);
        end
        @(posedge iClk); #1;
        bus.iReqValid = 2'b00;
        #2;
        iRstN = 1'b0;
        #1;
        checks++;
        if ({bus.oReqReady, bus.oRspValid, bus.oRspData, bus.oRspErr, bus.oMemAddress,
             bus.oMemWriteData, bus.oMemFunct3, bus.oMemWrite, bus.oMemRead} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: wr/rd=%b addr=%h wd=%h, want all 0",
                     {bus.oMemWrite, bus.oMemRead}, bus.oMemAddress, bus.oMemWriteData);
        end
        @(posedge iClk); #1;
        checks++;
        if (mem[12'h020] !== refMem[12'h020]) begin
            errors++;
            $display("FAIL rst_sb_aborted: mem20=%h, want %h", mem[12'h020], refMem[12'h020]);
        end
        iRstN = 1'b1;
        drive_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        drive_req(1, 1'b0, 32'h40, 32'h0, 3'b010);
        @(negedge iClk);
        checks++;
        if (bus.oReqReady !== 2'b01) begin
            errors++;
            $display("FAIL rst_ptr_grant: ready=%b, want 01", bus.oReqReady);
        end
        @(posedge iClk); #1;
        bus.iReqValid = 2'b00;
        @(negedge iClk);
        @(posedge iClk); #1;
        @(negedge iClk);
        checks++;
        if (bus.oRspValid !== 2'b01 || bus.oRspData !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rst_next_rsp: rspv=%b data=%h, want 01 deadbeef", bus.oRspValid,
                     bus.oRspData);
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          pWr [2];
        logic [31:0] pAddr [2];
        logic [2:0]  pF3 [2];
        bit          busy, expErr, expWr, lastG;
        int          bPort, bSince, w, r, sz, badMem;
        logic [31:0] expData, expAddr;
        logic [1:0]  expReady, expStrobe, expRspV;
        logic [2:0]  f3;
        logic [31:0] addr;
        pend[0] = 0; pend[1] = 0;
        busy = 0; bPort = 0; bSince = 0; expErr = 0; expWr = 0; expData = 0; expAddr = 0;
        lastG = 1'b0;  // the previous scenario ended with a port 0 grant
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && cyc < 440 && $urandom_range(0, 2) == 0) begin
                    pWr[p] = 1'($urandom_range(0, 1));
                    r = $urandom_range(0, 9);
                    if (pWr[p]) f3 = (r < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                    else if (r < 9) begin
                        f3 = 3'($urandom_range(0, 4));
                        if (f3 > 3'd2) f3 = f3 + 3'd1;
                    end else f3 = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7));
                    sz = acc_size(f3);
                    r  = $urandom_range(0, 9);
                    if (r < 7) begin
                        addr = 32'h100 + 32'($urandom_range(0, 63));
                        if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
                    end else if (r < 9) addr = 32'hFF8 + 32'($urandom_range(0, 7));
                    else addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                                            : 32'h1000 + 32'($urandom_range(0, 15));
                    pAddr[p] = addr;
                    pF3[p]   = f3;
                    drive_req(p, pWr[p], addr, $urandom, f3);
                    pend[p] = 1;
                end
            end
            bus.iReqValid = {pend[1], pend[0]};
            bus.iRspReady = (cyc >= 440) ? 2'b11 : 2'($urandom_range(0, 3));
            @(negedge iClk);
            expReady = 2'b00;
            w = -1;
            if (!busy) begin
                if (pend[0] && pend[1]) w = lastG ? 0 : 1;
                else if (pend[0]) w = 0;
                else if (pend[1]) w = 1;
                if (w >= 0) expReady = (w == 0) ? 2'b01 : 2'b10;
            end
            checks++;
            if (bus.oReqReady !== expReady) begin
                errors++;
                $display("FAIL rnd_ready cyc%0d: ready=%b, want %b", cyc, bus.oReqReady, expReady);
            end
            expStrobe = (busy && bSince == 1 && !expErr) ? (expWr ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({bus.oMemWrite, bus.oMemRead} !== expStrobe ||
                (expStrobe != 2'b00 && bus.oMemAddress !== expAddr)) begin
                errors++;
                $display("FAIL rnd_mem cyc%0d: wr/rd=%b addr=%h, want %b %h", cyc,
                         {bus.oMemWrite, bus.oMemRead}, bus.oMemAddress, expStrobe, expAddr);
            end
            expRspV = (busy && bSince >= 2) ? ((bPort == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (bus.oRspValid !== expRspV ||
                (expRspV != 2'b00 && (bus.oRspData !== expData || bus.oRspErr !== expErr))) begin
                errors++;
                $display("FAIL rnd_rsp cyc%0d: rspv=%b data=%h err=%b, want %b %h %b", cyc,
                         bus.oRspValid, bus.oRspData, bus.oRspErr, expRspV, expData, expErr);
            end
            if (busy) begin
                if (bSince >= 2 && bus.iRspReady[bPort]) busy = 0;
                else bSince++;
            end else if (w >= 0) begin
                busy    = 1;
                bSince  = 1;
                bPort   = w;
                lastG   = 1'(w);
                pend[w] = 0;
                expWr   = pWr[w];
                expAddr = pAddr[w];
                expErr  = ref_err(pWr[w], pAddr[w], pF3[w]);
                expData = (expErr || expWr) ? 32'h0 : ref_load(pAddr[w], pF3[w]);
                if (!expErr && expWr) ref_store(pAddr[w], (w == 0) ? bus.iReqWData0
                                                                   : bus.iReqWData1, pF3[w]);
            end
            @(posedge iClk); #1;
        end
        bus.iReqValid = 2'b00;
        checks++;
        if (busy || pend[0] || pend[1]) begin
            errors++;
            $display("FAIL rnd_drain: busy=%b pend=%b%b, want all idle", busy, pend[1], pend[0]);
        end
        badMem = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== refMem[i]) badMem++;
        checks++;
        if (badMem != 0) begin
            errors++;
            $display("FAIL rnd_mem_image: %0d bytes differ, want 0", badMem);
        end
    endtask

    initial begin
        bus.iReqValid = 2'b00; bus.iReqWrite = 2'b00; bus.iRspReady = 2'b00;
        bus.iReqAddr0 = 32'h0; bus.iReqAddr1 = 32'h0;
        bus.iReqWData0 = 32'h0; bus.iReqWData1 = 32'h0;
        bus.iReqFunct3_0 = 3'b000; bus.iReqFunct3_1 = 3'b000;
        busF.iReqValid = 2'b00; busF.iReqWrite = 2'b00; busF.iRspReady = 2'b00;
        busF.iReqAddr0 = 32'h0; busF.iReqAddr1 = 32'h0;
        busF.iReqWData0 = 32'h0; busF.iReqWData1 = 32'h0;
        busF.iReqFunct3_0 = 3'b000; busF.iReqFunct3_1 = 3'b000;
        memInit = 1'b1;
        for (int i = 0; i < 4096; i++) refMem[i] = 8'((i * 37 + 5) & 255);

        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
